// File: rtl/uart_tx_sched.sv
// Round-robin per-frame byte scheduler that shares one uart_tx serialiser between
// NREQ producers, with packet locking and a programmable inter-frame idle gap.
module uart_tx_sched #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic [NREQ-1:0]   req_valid_i,
  input  logic [8*NREQ-1:0] req_data_i,
  input  logic [NREQ-1:0]   req_last_i,
  input  logic [NREQ-1:0]   req_enable_i,
  output logic [NREQ-1:0]   req_ready_o,
  input  logic [7:0]        gap_i,
  output logic              tx_start_o,
  output logic [7:0]        tx_byte_o,
  input  logic              tx_dequeue_i,
  input  logic              tx_busy_i,
  output logic [NREQ-1:0]   grant_o,
  output logic              locked_o,
  output logic              done_o,
  output logic [IDW-1:0]    done_id_o
);

  localparam logic [1:0] ST_ARB   = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_GAP   = 2'd3;

  logic [1:0]      state;
  logic [IDW-1:0]  ptr;
  logic [IDW-1:0]  winner;
  logic [IDW-1:0]  cand;
  logic            lock;
  logic [7:0]      gap_cnt;
  logic [7:0]      hold_byte;
  logic [NREQ-1:0] eligible;
  logic            found;
  logic            fire;

  // Search ptr+1, ptr+2, ... so the last winner has lowest priority next time.
  always_comb begin
    eligible = req_valid_i & req_enable_i;
    if (lock) begin
      eligible = eligible & (NREQ'(1) << ptr);
    end
    found  = 1'b0;
    winner = ptr;
    cand   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IDW'((int'(ptr) + k) % NREQ);
      if (!found && eligible[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  // The cycle carrying the registered done pulse is skipped so done_o and
  // req_ready_o can never coincide.
  assign fire        = resetn && (state == ST_ARB) && !tx_busy_i && !done_o && found;
  assign req_ready_o = fire ? (NREQ'(1) << winner) : '0;
  assign tx_start_o  = (state == ST_START);
  assign tx_byte_o   = hold_byte;
  assign locked_o    = lock;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state     <= ST_ARB;
      ptr       <= IDW'(NREQ - 1);
      lock      <= 1'b0;
      gap_cnt   <= 8'd0;
      hold_byte <= 8'd0;
      grant_o   <= '0;
      done_o    <= 1'b0;
      done_id_o <= '0;
    end else begin
      done_o <= 1'b0;
      if (!fire && lock && !req_enable_i[ptr]) begin
        lock <= 1'b0;
      end
      case (state)
        ST_ARB: begin
          if (fire) begin
            hold_byte <= req_data_i[{winner, 3'b000} +: 8];
            ptr       <= winner;
            grant_o   <= NREQ'(1) << winner;
            lock      <= ~req_last_i[winner];
            state     <= ST_START;
          end
        end
        ST_START: state <= ST_WAIT;
        ST_WAIT: begin
          if (tx_dequeue_i) begin
            done_o    <= 1'b1;
            done_id_o <= ptr;
            if (gap_i == 8'd0) begin
              state <= ST_ARB;
            end else begin
              gap_cnt <= gap_i;
              state   <= ST_GAP;
            end
          end
        end
        default: begin
          if (gap_cnt <= 8'd1) begin
            gap_cnt <= 8'd0;
            state   <= ST_ARB;
          end else begin
            gap_cnt <= gap_cnt - 8'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed self-checking bench for uart_tx_sched: queued byte producers plus a
// small serialiser model; expected byte/grant orders are hand-derived constants.
module tb_uart_tx_sched;

  localparam int NREQ = 4;

  logic              clock = 1'b0;
  logic              resetn;
  logic [NREQ-1:0]   req_valid_i;
  logic [8*NREQ-1:0] req_data_i;
  logic [NREQ-1:0]   req_last_i;
  logic [NREQ-1:0]   req_enable_i;
  logic [NREQ-1:0]   req_ready_o;
  logic [7:0]        gap_i;
  logic              tx_start_o;
  logic [7:0]        tx_byte_o;
  logic              tx_dequeue_i;
  logic              tx_busy_i;
  logic [NREQ-1:0]   grant_o;
  logic              locked_o;
  logic              done_o;
  logic [1:0]        done_id_o;

  uart_tx_sched #(.NREQ(NREQ)) dut (
    .clock(clock), .resetn(resetn),
    .req_valid_i(req_valid_i), .req_data_i(req_data_i), .req_last_i(req_last_i),
    .req_enable_i(req_enable_i), .req_ready_o(req_ready_o), .gap_i(gap_i),
    .tx_start_o(tx_start_o), .tx_byte_o(tx_byte_o), .tx_dequeue_i(tx_dequeue_i),
    .tx_busy_i(tx_busy_i), .grant_o(grant_o), .locked_o(locked_o),
    .done_o(done_o), .done_id_o(done_id_o)
  );

  always #5 clock = ~clock;

  logic [8:0]      srcQ [NREQ][$];
  logic [7:0]      startByteQ [$];
  int              startIdQ [$];
  logic            startLockQ [$];
  int              doneIdQ [$];
  logic [NREQ-1:0] acceptMask;
  logic            startSeen, prevStart, serBusy, busyForce;
  int              serCnt, serLen;
  int              checkCount, passCount, overlapCount, dblStartCount;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    else passCount++;
  endtask

  function automatic int oneHotIdx(input logic [NREQ-1:0] v);
    for (int i = 0; i < NREQ; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic refreshReq();
    logic [8:0] e;
    for (int i = 0; i < NREQ; i++) begin
      if (srcQ[i].size() > 0) begin
        e = srcQ[i][0];
        req_valid_i[i]         = 1'b1;
        req_data_i[8*i +: 8]   = e[7:0];
        req_last_i[i]          = e[8];
      end else begin
        req_valid_i[i] = 1'b0;
        req_last_i[i]  = 1'b0;
      end
    end
  endtask

  task automatic applyStimulus(input int idx, input logic [7:0] b, input logic last);
    srcQ[idx].push_back({last, b});
    refreshReq();
  endtask

  task automatic clearLogs();
    startByteQ.delete(); startIdQ.delete(); startLockQ.delete(); doneIdQ.delete();
  endtask

  // Mid-cycle observation: logs starts/dones and remembers which bytes get taken.
  task automatic sample();
    @(negedge clock);
    if (tx_start_o) begin
      startByteQ.push_back(tx_byte_o);
      startIdQ.push_back(oneHotIdx(grant_o));
      startLockQ.push_back(locked_o);
    end
    if (done_o) doneIdQ.push_back(int'(done_id_o));
    if (done_o && (req_ready_o != '0)) overlapCount++;
    if (tx_start_o && prevStart) dblStartCount++;
    prevStart  = tx_start_o;
    startSeen  = tx_start_o;
    acceptMask = req_ready_o & req_valid_i;
  endtask

  // Just after the edge: retire accepted bytes and step the serialiser model.
  task automatic advance();
    @(posedge clock);
    #1;
    for (int i = 0; i < NREQ; i++)
      if (acceptMask[i] && srcQ[i].size() > 0) void'(srcQ[i].pop_front());
    acceptMask = '0;
    if (!resetn) begin
      serBusy = 1'b0; serCnt = 0; tx_dequeue_i = 1'b0;
    end else if (tx_dequeue_i) begin
      tx_dequeue_i = 1'b0; serBusy = 1'b0;
    end else if (startSeen) begin
      serBusy = 1'b1; serCnt = serLen;
    end else if (serCnt > 0) begin
      serCnt--;
      if (serCnt == 0) tx_dequeue_i = 1'b1;
    end
    startSeen = 1'b0;
    tx_busy_i = serBusy | busyForce;
    refreshReq();
  endtask

  task automatic resetDut();
    resetn = 1'b0;
    for (int i = 0; i < NREQ; i++) srcQ[i].delete();
    req_enable_i = '1;
    refreshReq();
    advance();
    advance();
    resetn = 1'b1;
    clearLogs();
  endtask

  task automatic runFrames(input int n, input int budget, input string tag);
    logic found = 1'b0;
    for (int k = 0; k < budget; k++) begin
      sample();
      if (doneIdQ.size() >= n) found = 1'b1;
      advance();
      if (found) break;
    end
    checkOutput({tag, "_frames"}, 32'(found), 32'd1);
  endtask

  // Leaves the bench just after the sample where the n-th start appeared.
  task automatic waitStarts(input int n, input int budget, input string tag);
    logic found = 1'b0;
    for (int k = 0; k < budget; k++) begin
      sample();
      if (startByteQ.size() >= n) begin found = 1'b1; break; end
      advance();
    end
    checkOutput({tag, "_start"}, 32'(found), 32'd1);
  endtask

  task automatic measureGap(input int expGap, input logic [7:0] midGap, input string tag);
    logic ok = 1'b0;
    int   n  = 0;
    for (int k = 0; k < 200; k++) begin
      sample();
      if (done_o) begin ok = 1'b1; break; end
      advance();
    end
    checkOutput({tag, "_done"}, 32'(ok), 32'd1);
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (req_ready_o != '0) begin ok = 1'b1; break; end
      n++;
      advance();
      if (k == 0) gap_i = midGap;
      sample();
    end
    checkOutput({tag, "_ready"}, 32'(ok), 32'd1);
    checkOutput(tag, 32'(n), 32'(expGap));
    advance();
  endtask

  initial begin
    logic [7:0] expB [4];
    int         expI [4];
    checkCount = 0; passCount = 0; overlapCount = 0; dblStartCount = 0;
    resetn = 1'b0; req_valid_i = '0; req_data_i = '0; req_last_i = '0;
    req_enable_i = '1; gap_i = 8'd0; tx_dequeue_i = 1'b0; tx_busy_i = 1'b0;
    serBusy = 1'b0; busyForce = 1'b0; serCnt = 0; serLen = 2;
    startSeen = 1'b0; prevStart = 1'b0; acceptMask = '0;

    // 1: reset values, single byte, start latency, done id
    advance();
    applyStimulus(0, 8'h55, 1'b1);
    sample();
    checkOutput("rst_ready", 32'(req_ready_o), 32'd0);
    checkOutput("rst_start", 32'(tx_start_o), 32'd0);
    checkOutput("rst_byte", 32'(tx_byte_o), 32'd0);
    checkOutput("rst_grant", 32'(grant_o), 32'd0);
    checkOutput("rst_locked", 32'(locked_o), 32'd0);
    checkOutput("rst_done", 32'(done_o), 32'd0);
    checkOutput("rst_doneid", 32'(done_id_o), 32'd0);
    advance();
    resetn = 1'b1;
    sample();
    checkOutput("t1_ready", 32'(req_ready_o), 32'h1);
    checkOutput("t1_start_early", 32'(tx_start_o), 32'd0);
    advance();
    sample();
    checkOutput("t1_start", 32'(tx_start_o), 32'd1);
    checkOutput("t1_byte", 32'(tx_byte_o), 32'h55);
    checkOutput("t1_grant", 32'(grant_o), 32'h1);
    checkOutput("t1_ready_off", 32'(req_ready_o), 32'd0);
    advance();
    runFrames(1, 50, "t1");
    checkOutput("t1_doneid", 32'(doneIdQ[0]), 32'd0);
    checkOutput("t1_nstart", 32'(startByteQ.size()), 32'd1);

    // 2: four contending requesters, fresh pointer -> 0,1,2,3,0,1,2,3
    resetDut();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NREQ; i++) applyStimulus(i, 8'hA0 + 8'(i), 1'b1);
    runFrames(8, 300, "t2");
    checkOutput("t2_nstart", 32'(startByteQ.size()), 32'd8);
    for (int f = 0; f < 8; f++) begin
      checkOutput($sformatf("t2_byte%0d", f), 32'(startByteQ[f]), 32'hA0 + 32'(f % 4));
      checkOutput($sformatf("t2_id%0d", f), 32'(startIdQ[f]), 32'(f % 4));
    end

    // 3: req2 packet of three bytes locks out req1
    resetDut();
    applyStimulus(2, 8'h21, 1'b0);
    applyStimulus(2, 8'h22, 1'b0);
    applyStimulus(2, 8'h23, 1'b1);
    sample();
    checkOutput("t3_ready", 32'(req_ready_o), 32'h4);
    advance();
    applyStimulus(1, 8'h11, 1'b1);
    runFrames(4, 300, "t3");
    expB = '{8'h21, 8'h22, 8'h23, 8'h11};
    expI = '{2, 2, 2, 1};
    for (int f = 0; f < 4; f++) begin
      checkOutput($sformatf("t3_byte%0d", f), 32'(startByteQ[f]), 32'(expB[f]));
      checkOutput($sformatf("t3_id%0d", f), 32'(startIdQ[f]), 32'(expI[f]));
    end
    checkOutput("t3_lock0", 32'(startLockQ[0]), 32'd1);
    checkOutput("t3_lock1", 32'(startLockQ[1]), 32'd1);
    checkOutput("t3_lock2", 32'(startLockQ[2]), 32'd0);
    checkOutput("t3_unlocked", 32'(locked_o), 32'd0);

    // 4: gap of 5 ignores a mid-gap change to 9; the next frame uses 9
    resetDut();
    gap_i = 8'd5;
    applyStimulus(0, 8'h41, 1'b1);
    applyStimulus(0, 8'h42, 1'b1);
    applyStimulus(0, 8'h43, 1'b1);
    measureGap(5, 8'd9, "t4_gap5");
    measureGap(9, 8'd9, "t4_gap9");
    gap_i = 8'd0;
    runFrames(3, 300, "t4");
    checkOutput("t4_byte2", 32'(startByteQ[2]), 32'h43);

    // 5: disabled requester never granted; dropping a locked owner's enable
    resetDut();
    req_enable_i = 4'b1011;
    for (int i = 0; i < NREQ; i++) applyStimulus(i, 8'hB0 + 8'(i), 1'b1);
    runFrames(3, 300, "t5a");
    for (int k = 0; k < 20; k++) begin sample(); advance(); end
    checkOutput("t5_nstart", 32'(startByteQ.size()), 32'd3);
    checkOutput("t5_byte2", 32'(startByteQ[2]), 32'hB3);
    checkOutput("t5_q2left", 32'(srcQ[2].size()), 32'd1);
    clearLogs();
    req_enable_i = 4'b1111;
    applyStimulus(1, 8'hC1, 1'b0);
    applyStimulus(1, 8'hC2, 1'b0);
    applyStimulus(1, 8'hC3, 1'b0);
    applyStimulus(3, 8'hD3, 1'b1);
    waitStarts(2, 100, "t5b");
    advance();
    req_enable_i = 4'b1101;
    sample();
    checkOutput("t5_still_locked", 32'(locked_o), 32'd1);
    advance();
    sample();
    checkOutput("t5_lock_drop", 32'(locked_o), 32'd0);
    advance();
    runFrames(4, 300, "t5b");
    for (int k = 0; k < 20; k++) begin sample(); advance(); end
    expB = '{8'hC1, 8'hC2, 8'hB2, 8'hD3};
    for (int f = 0; f < 4; f++)
      checkOutput($sformatf("t5_byte%0d", f), 32'(startByteQ[f]), 32'(expB[f]));
    checkOutput("t5_nstart2", 32'(startByteQ.size()), 32'd4);
    checkOutput("t5_q1left", 32'(srcQ[1].size()), 32'd1);

    // 6: reset during WAIT, busy blocks issue, pointer back at NREQ-1
    resetDut();
    applyStimulus(0, 8'hE0, 1'b1);
    waitStarts(1, 50, "t6a");
    advance();
    applyStimulus(0, 8'hE2, 1'b1);
    applyStimulus(1, 8'hE1, 1'b1);
    resetn = 1'b0;
    sample();
    advance();
    sample();
    checkOutput("t6_ready", 32'(req_ready_o), 32'd0);
    checkOutput("t6_start", 32'(tx_start_o), 32'd0);
    checkOutput("t6_grant", 32'(grant_o), 32'd0);
    checkOutput("t6_locked", 32'(locked_o), 32'd0);
    checkOutput("t6_done", 32'(done_o), 32'd0);
    checkOutput("t6_byte", 32'(tx_byte_o), 32'd0);
    advance();
    clearLogs();
    resetn = 1'b1;
    busyForce = 1'b1;
    tx_busy_i = 1'b1;
    sample();
    checkOutput("t6_busy_block", 32'(req_ready_o), 32'd0);
    advance();
    busyForce = 1'b0;
    tx_busy_i = serBusy;
    sample();
    checkOutput("t6_ready0", 32'(req_ready_o), 32'h1);
    advance();
    waitStarts(1, 50, "t6b");
    checkOutput("t6_first_byte", 32'(startByteQ[0]), 32'hE2);
    checkOutput("t6_first_id", 32'(startIdQ[0]), 32'd0);
    advance();
    runFrames(2, 200, "t6");
    checkOutput("t6_doneid1", 32'(doneIdQ[1]), 32'd1);

    checkOutput("done_ready_overlap", 32'(overlapCount), 32'd0);
    checkOutput("double_start", 32'(dblStartCount), 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
Round-robin byte scheduler that shares one uart_tx serialiser between NREQ independent byte producers (CPU TX FIFO, debug console, DMA, ...).
- Arbitrates per frame.
- Optionally locks the line to one requester for a multi-byte packet.
- Issues exactly one start pulse per byte and waits for frame completion.
- Inserts a programmable idle gap between frames.
- Sits between the TileLink UART register/FIFO logic and the uart_tx datapath.

Parameters:
NREQ, 4, number of requesters (2..8)
IDW, $clog2(NREQ), width of requester index

Ports:
clock  in  1  system clock
resetn  in  1  reset, synchronous, active-low
req_valid_i  in  NREQ  requester i has a byte
req_data_i  in  8*NREQ  byte of requester i at [8*i+7:8*i]
req_last_i  in  NREQ  byte is last of packet (releases lock)
req_enable_i  in  NREQ  requester i may be granted
req_ready_o  out  NREQ  accept strobe; byte i taken when valid&ready
gap_i  in  8  idle cycles inserted after each frame completes
tx_start_o  out  1  one-cycle start pulse to serialiser tx_i
tx_byte_o  out  8  byte to serialiser, valid while tx_start_o
tx_dequeue_i  in  1  serialiser frame-complete pulse
tx_busy_i  in  1  serialiser busy
grant_o  out  NREQ  one-hot owner of current/last frame, 0 after reset
locked_o  out  1  line locked to grant_o owner mid-packet
done_o  out  1  one-cycle pulse when a frame completes
done_id_o  out  IDW  requester index of completed frame

Behaviour:
- State machine: ARB, START, WAIT, GAP.
- Reset (resetn=0 at posedge) forces:
  - state=ARB, rr pointer=NREQ-1, lock=0, gap counter=0, hold byte=0;
  - all outputs 0, including req_ready_o, tx_start_o, grant_o, done_o.
  - Reset mid-frame abandons the frame; the serialiser shares resetn.
- Eligibility:
  - eligible[i] = req_valid_i[i] & req_enable_i[i].
  - If locked, only the owner is eligible.
  - If the owner's req_enable_i drops while locked, the lock clears at the next posedge and normal arbitration resumes.
- ARB:
  - Acts only when tx_busy_i=0 and at least one requester is eligible.
  - Winner w = first eligible index searching ptr+1, ptr+2, ... mod NREQ.
  - req_ready_o[w]=1 combinationally in that cycle; all other ready bits are 0.
  - At the posedge: hold byte <= req_data_i[w]; ptr <= w; grant_o <= onehot(w); lock <= ~req_last_i[w]; state -> START.
- START:
  - tx_start_o=1 and tx_byte_o=hold byte for exactly one cycle; state -> WAIT.
  - tx_start_o is never high in any other state.
- WAIT:
  - Holds until tx_dequeue_i=1.
  - In that cycle done_o=1 (registered pulse next cycle) and done_id_o=ptr.
  - If gap_i=0 -> ARB; else gap counter <= gap_i and -> GAP.
- GAP:
  - Counter decrements each cycle; at 1 -> ARB.
  - gap_i is sampled only on entry; later changes are ignored until the next frame.
- Timing:
  - Byte accepted in cycle A; tx_start_o in A+1.
  - Next accept no earlier than 1+gap_i cycles after tx_dequeue_i.
- tx_busy_i=1 in ARB (e.g. a stale frame after a partial reset) blocks issue, so the serialiser is never pulsed while its byte register is live.
- Requesters must hold valid and data stable until accepted. Dropping valid before ready is permitted; that byte is simply not sent.
- A lone byte with last=1 never locks; a single requester streaming last=0 locks indefinitely (by design).
- Simultaneous tx_dequeue_i with a requester's valid rising: the byte is not accepted until ARB.
- done_o and req_ready_o are never high in the same cycle.

Test Plan:
1. Reset, NREQ=4, gap_i=0, req0 valid data 0x55 last=1 -> req_ready_o=0001 in the first ARB cycle, tx_start_o one cycle later with tx_byte_o=0x55, done_o/done_id_o=0 after tx_dequeue_i.
2. All four valid, last=1, data 0xA0..0xA3, continuously refilled -> grant order 0,1,2,3,0; exactly one tx_start_o per frame.
3. req2 sends 3 bytes (last=0,0,1) while req1 is valid throughout -> bytes 2,2,2 then 1; locked_o=1 during the first two frames, 0 after the third.
4. gap_i=5 -> exactly 5 idle cycles in GAP between the tx_dequeue_i cycle+1 and the next ready; changing gap_i to 9 mid-gap has no effect.
5. req_enable_i=1011 with all valid -> req2 never granted; dropping enable of a locked owner -> lock released and the next eligible requester is granted.
6. Assert resetn=0 during WAIT -> all outputs 0 next cycle, state ARB, ptr=NREQ-1, so req0 wins the first arbitration after reset.
